mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the
//   pipelined CPU. Sits beside the ALU in EX; MULT/MULTU/DIV/DIVU run for a fixed, configurable
//   latency while busy is asserted, and MTHI/MTLO/MFHI/MFLO give direct access to HI/LO.
//   Operand width and per-class latencies are configurable; in-flight ops can be flushed.
// PARAMETERS
//   WIDTH        32  operand / HI / LO width in bits (>= 2)
//   MULT_CYCLES   5  busy cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (>= 1)
// PORTS
//   clk      in   1      clock, all state updates on rising edge
//   reset    in   1      asynchronous, active-high reset
//   start    in   1      issue mdu_op this cycle
//   mdu_op   in   3      000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//   src_a    in   WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
//   src_b    in   WIDTH  rt operand (divisor / multiplier)
//   flush    in   1      abort in-flight mult/div; HI/LO keep old values
//   busy     out  1      registered; high while a mult/div is in flight
//   hi       out  WIDTH  HI register (MFHI source)
//   lo       out  WIDTH  LO register (MFLO source)
// BEHAVIOUR
//   - Reset (async, any time): busy=0, hi=0, lo=0, counter=0, pending result discarded, FSM=IDLE.
//   - FSM: IDLE, RUN. Operand latch + result computed at issue into pending_hi/pending_lo.
//   - IDLE & start & op in {MULT,MULTU}: edge T0 latches result, counter=MULT_CYCLES, -> RUN,
//     busy=1 after T0. DIV/DIVU same with DIV_CYCLES.
//   - RUN: counter decrements each edge; at edge where counter goes 1->0: hi/lo <= pending,
//     busy=0, -> IDLE. So busy is high for exactly N cycles; new HI/LO visible the cycle busy falls.
//   - start with op in {MULT..DIVU} issued the cycle busy falls (FSM already IDLE) is accepted.
//   - MTHI/MTLO in IDLE: hi (resp. lo) <= src_a at that edge; busy stays 0; other reg unchanged.
//   - Any start while busy=1 (incl. MTHI/MTLO) is ignored; hazard logic must stall on start|busy.
//   - mdu_op 000 or 111 with start: no effect.
//   - flush: if RUN, -> IDLE next edge, busy=0, hi/lo unchanged, pending dropped. A start in the
//     same cycle as flush is ignored (flush wins). flush in IDLE: no effect.
//   - Arithmetic: MULT signed WIDTHxWIDTH -> 2*WIDTH; {hi,lo} = product. MULTU unsigned.
//   - DIV signed, truncating toward zero: lo = quotient, hi = remainder (sign of dividend).
//     DIVU unsigned.
//   - Divide by zero (DIV/DIVU): lo = all ones, hi = src_a; full latency still applies.
//   - DIV overflow (src_a = -2^(WIDTH-1), src_b = -1): lo = src_a, hi = 0.
//   - hi/lo change only at: reset, MTHI/MTLO edge, completion edge. Never mid-op.
// TESTING
//   - MULT src_a=FFFFFFFD (-3), src_b=5 -> busy high exactly 5 cycles; then hi=FFFFFFFF, lo=FFFFFFF1.
//   - DIV -7/2 -> after 10 busy cycles lo=FFFFFFFD, hi=FFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
//   - DIVU 1234/0 -> lo=FFFFFFFF, hi=000004D2; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//   - MULTU 3*4 then MTHI 55 at cycle 2 of busy -> MTHI ignored; final hi=0, lo=C.
//   - MULT issued, flush at busy cycle 3 -> busy=0 next cycle, hi/lo keep prior values; reset
//     asserted mid-DIV -> busy, hi, lo = 0 immediately, no late write-back after release.
//   - Param sweep WIDTH=8, MULT_CYCLES=1, DIV_CYCLES=3: MULTU FF*FF -> hi=FE, lo=01 after 1 cycle.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue and held pending until the fixed latency expires.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b, div_bs, div_bu;
    logic [WIDTH-1:0]   q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;

    // Signed divide is done on magnitudes; the min/-1 overflow case falls out as quotient = src_a.
    always_comb begin
        prod_s   = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
        prod_u   = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
        a_neg    = src_a[WIDTH-1];
        b_neg    = src_b[WIDTH-1];
        div_zero = (src_b == '0);
        mag_a    = a_neg ? (~src_a + 1'b1) : src_a;
        mag_b    = b_neg ? (~src_b + 1'b1) : src_b;
        div_bs   = div_zero ? WIDTH'(1) : mag_b;
        div_bu   = div_zero ? WIDTH'(1) : src_b;
        q_mag    = mag_a / div_bs;
        r_mag    = mag_a % div_bs;
        quot_s   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        rem_s    = a_neg ? (~r_mag + 1'b1) : r_mag;
        quot_u   = src_a / div_bu;
        rem_u    = src_a % div_bu;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (mdu_op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            count_d = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            count_d = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV: begin
                            pend_hi_d = div_zero ? src_a : rem_s;
                            pend_lo_d = div_zero ? '1 : quot_s;
                            count_d   = CW'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_d = div_zero ? src_a : rem_u;
                            pend_lo_d = div_zero ? '1 : quot_u;
                            count_d   = CW'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Flush beats completion so an aborted op can never write back.
                if (flush) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (count_q == CW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases, random ops against an arithmetic
// reference model, flush/reset/hazard behaviour and a small-width parameter instance.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    logic        s_start = 1'b0;
    logic [2:0]  s_mdu_op = 3'd0;
    logic [7:0]  s_src_a = '0;
    logic [7:0]  s_src_b = '0;
    logic        s_busy;
    logic [7:0]  s_hi, s_lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] model_hl = '0;

    mdu_unit dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .hi(hi), .lo(lo)
    );

    mdu_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .mdu_op(s_mdu_op),
        .src_a(s_src_a), .src_b(s_src_b), .flush(1'b0),
        .busy(s_busy), .hi(s_hi), .lo(s_lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: MIPS HI/LO semantics in plain 64-bit arithmetic.
    function automatic logic [63:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] cur);
        longint q, r;
        logic [63:0] res;
        res = cur;
        case (op)
            3'd1: res = 64'(longint'($signed(a)) * longint'($signed(b)));
            3'd2: res = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            3'd5: res = {a, cur[31:0]};
            3'd6: res = {cur[63:32], a};
            default: res = cur;
        endcase
        return res;
    endfunction

    function automatic int model_cycles(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; mdu_op = op; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; mdu_op = 3'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        checks++; if ({s_busy, s_hi, s_lo} !== 17'd0) begin errors++; $display("[TB] FAIL reset_small: got %h expected 0", {s_busy, s_hi, s_lo}); end
        reset = 1'b0;
        model_hl = '0;
        @(negedge clk);
    endtask

    logic [2:0]  d_op [5] = '{3'd1, 3'd3, 3'd4, 3'd4, 3'd3};
    logic [31:0] d_a  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'd1234, 32'h8000_0000};
    logic [31:0] d_b  [5] = '{32'd5, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] d_hi [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h0000_04D2, 32'd0};
    logic [31:0] d_lo [5] = '{32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
    int          d_cy [5] = '{5, 10, 10, 10, 10};

    task automatic test_directed;
        int n;
        for (int i = 0; i < 5; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            wait_idle(n);
            checks++; if (n !== d_cy[i]) begin errors++; $display("[TB] FAIL directed%0d_cycles: got %0d expected %0d", i, n, d_cy[i]); end
            checks++; if (hi !== d_hi[i]) begin errors++; $display("[TB] FAIL directed%0d_hi: got %h expected %h", i, hi, d_hi[i]); end
            checks++; if (lo !== d_lo[i]) begin errors++; $display("[TB] FAIL directed%0d_lo: got %h expected %h", i, lo, d_lo[i]); end
            model_hl = {d_hi[i], d_lo[i]};
        end
    endtask

    task automatic test_mthi_mtlo;
        int n;
        issue(3'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        wait_idle(n);
        checks++; if (n !== 0) begin errors++; $display("[TB] FAIL mthi_busy: got %0d cycles expected 0", n); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mthi_hi: got %h expected 12345678", hi); end
        checks++; if (lo !== model_hl[31:0]) begin errors++; $display("[TB] FAIL mthi_lo_kept: got %h expected %h", lo, model_hl[31:0]); end
        model_hl = {32'h1234_5678, model_hl[31:0]};
        issue(3'd6, 32'h0BAD_F00D, 32'd0);
        checks++; if (lo !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL mtlo_lo: got %h expected 0badf00d", lo); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mtlo_hi_kept: got %h expected 12345678", hi); end
        model_hl = {32'h1234_5678, 32'h0BAD_F00D};
        issue(3'd7, 32'h1111_1111, 32'h2222_2222);
        issue(3'd0, 32'h3333_3333, 32'h4444_4444);
        checks++; if ({busy, hi, lo} !== {1'b0, model_hl}) begin errors++; $display("[TB] FAIL noop_ops: got %h expected %h", {busy, hi, lo}, {1'b0, model_hl}); end
    endtask

    task automatic test_busy_ignore;
        int n;
        issue(3'd2, 32'd3, 32'd4);
        @(negedge clk);
        start = 1'b1; mdu_op = 3'd5; src_a = 32'h55;
        @(negedge clk);
        start = 1'b0; mdu_op = 3'd0;
        checks++; if (hi !== model_hl[63:32]) begin errors++; $display("[TB] FAIL ignore_midop_hi: got %h expected %h", hi, model_hl[63:32]); end
        wait_idle(n);
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL ignore_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'hC) begin errors++; $display("[TB] FAIL ignore_lo: got %h expected c", lo); end
        model_hl = 64'hC;
    endtask

    task automatic test_flush;
        issue(3'd5, 32'hAAAA_5555, 32'd0);
        issue(3'd6, 32'h1234_ABCD, 32'd0);
        model_hl = {32'hAAAA_5555, 32'h1234_ABCD};
        issue(3'd1, $urandom, $urandom);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_busy: got %b expected 1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
        repeat (8) @(negedge clk);
        checks++; if ({hi, lo} !== model_hl) begin errors++; $display("[TB] FAIL flush_hilo: got %h expected %h", {hi, lo}, model_hl); end
    endtask

    task automatic test_reset_mid_div;
        issue(3'd3, $urandom | 32'h1, 32'd3);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if ({busy, hi, lo} !== 65'd0) begin errors++; $display("[TB] FAIL reset_mid_div: got %h expected 0", {busy, hi, lo}); end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if ({busy, hi, lo} !== 65'd0) begin errors++; $display("[TB] FAIL reset_no_late_wb: got %h expected 0", {busy, hi, lo}); end
        model_hl = '0;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        issue(3'd1, a, b);
        wait_idle(n);
        model_hl = model_op(3'd1, a, b, model_hl);
        checks++; if (n !== 5) begin errors++; $display("[TB] FAIL b2b_mult_cycles: got %0d expected 5", n); end
        checks++; if ({hi, lo} !== model_hl) begin errors++; $display("[TB] FAIL b2b_mult: got %h expected %h", {hi, lo}, model_hl); end
        a = $urandom; b = $urandom_range(1, 1000);
        start = 1'b1; mdu_op = 3'd3; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; mdu_op = 3'd0;
        wait_idle(n);
        model_hl = model_op(3'd3, a, b, model_hl);
        checks++; if (n !== 10) begin errors++; $display("[TB] FAIL b2b_div_cycles: got %0d expected 10", n); end
        checks++; if ({hi, lo} !== model_hl) begin errors++; $display("[TB] FAIL b2b_div: got %h expected %h", {hi, lo}, model_hl); end
    endtask

    task automatic test_random;
        int n;
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(1, 6));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 50)) ^ {32{b[31]}};
            issue(op, a, b);
            wait_idle(n);
            model_hl = model_op(op, a, b, model_hl);
            checks++; if (n !== model_cycles(op)) begin errors++; $display("[TB] FAIL rand%0d_cycles op=%0d: got %0d expected %0d", i, op, n, model_cycles(op)); end
            checks++; if (hi !== model_hl[63:32]) begin errors++; $display("[TB] FAIL rand%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, hi, model_hl[63:32]); end
            checks++; if (lo !== model_hl[31:0]) begin errors++; $display("[TB] FAIL rand%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, lo, model_hl[31:0]); end
        end
    endtask

    task automatic test_param_sweep;
        int n;
        @(negedge clk);
        s_start = 1'b1; s_mdu_op = 3'd2; s_src_a = 8'hFF; s_src_b = 8'hFF;
        @(negedge clk);
        s_start = 1'b0; s_mdu_op = 3'd0;
        checks++; if (s_busy !== 1'b1) begin errors++; $display("[TB] FAIL small_mult_busy: got %b expected 1", s_busy); end
        @(negedge clk);
        checks++; if (s_busy !== 1'b0) begin errors++; $display("[TB] FAIL small_mult_done: got %b expected 0", s_busy); end
        checks++; if ({s_hi, s_lo} !== 16'hFE01) begin errors++; $display("[TB] FAIL small_multu: got %h expected fe01", {s_hi, s_lo}); end
        s_start = 1'b1; s_mdu_op = 3'd3; s_src_a = 8'hF9; s_src_b = 8'h02;
        @(negedge clk);
        s_start = 1'b0; s_mdu_op = 3'd0;
        n = 0;
        while (s_busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 3) begin errors++; $display("[TB] FAIL small_div_cycles: got %0d expected 3", n); end
        checks++; if ({s_hi, s_lo} !== 16'hFFFD) begin errors++; $display("[TB] FAIL small_div: got %h expected fffd", {s_hi, s_lo}); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_mthi_mtlo;
        test_busy_ignore;
        test_flush;
        test_reset_mid_div;
        test_back_to_back;
        test_random;
        test_param_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
